// File: rtl/uart_param_core.sv
// Full-duplex UART with configurable frame (data bits, parity, stop bits), oversampled
// receiver with synchroniser, glitch rejection, 3-sample majority vote and break handling.
module uart_param_core #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = 4;
  localparam logic [OS_W-1:0]  TICK_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  TICK_S0   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  TICK_S1   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  TICK_S2   = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t               tx_state_reg;
  logic [DIV_W-1:0]     tx_div_reg;
  logic [DIV_W-1:0]     tx_pre_reg;
  logic [OS_W-1:0]      tx_tick_reg;
  logic [BIT_W-1:0]     tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_pre_reg == tx_div_reg) && (tx_tick_reg == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_reg <= S_IDLE;
      tx_div_reg   <= '0;
      tx_pre_reg   <= '0;
      tx_tick_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_state_reg == S_IDLE) begin
        tx <= 1'b1;
        if (tx_start) begin
          tx_state_reg <= S_START;
          tx_busy      <= 1'b1;
          tx           <= 1'b0;
          tx_shift_reg <= tx_data;
          tx_par_reg   <= (^tx_data) ^ PAR_ODD;
          tx_div_reg   <= baud_div;
          tx_pre_reg   <= '0;
          tx_tick_reg  <= '0;
          tx_bit_reg   <= '0;
        end
      end else begin
        if (tx_pre_reg == tx_div_reg) begin
          tx_pre_reg  <= '0;
          tx_tick_reg <= (tx_tick_reg == TICK_LAST) ? '0 : tx_tick_reg + 1'b1;
        end else begin
          tx_pre_reg <= tx_pre_reg + 1'b1;
        end
        if (tx_bit_end) begin
          case (tx_state_reg)
            S_START: begin
              tx_state_reg <= S_DATA;
              tx           <= tx_shift_reg[0];
            end
            S_DATA: begin
              if (tx_bit_reg == DATA_LAST) begin
                tx_bit_reg <= '0;
                if (PARITY != 0) begin
                  tx_state_reg <= S_PARITY;
                  tx           <= tx_par_reg;
                end else begin
                  tx_state_reg <= S_STOP;
                  tx           <= 1'b1;
                end
              end else begin
                // next bit is presented from bit 1 before the shift lands
                tx_bit_reg   <= tx_bit_reg + 1'b1;
                tx           <= tx_shift_reg[1];
                tx_shift_reg <= tx_shift_reg >> 1;
              end
            end
            S_PARITY: begin
              tx_state_reg <= S_STOP;
              tx           <= 1'b1;
            end
            S_STOP: begin
              if (tx_bit_reg == STOP_LAST) begin
                tx_state_reg <= S_IDLE;
                tx_busy      <= 1'b0;
                tx_done      <= 1'b1;
              end else begin
                tx_bit_reg <= tx_bit_reg + 1'b1;
              end
            end
            default: tx_state_reg <= S_IDLE;
          endcase
        end
      end
    end
  end

  state_t               rx_state_reg;
  logic [1:0]           rx_sync_reg;
  logic [DIV_W-1:0]     rx_div_reg;
  logic [DIV_W-1:0]     rx_pre_reg;
  logic [OS_W-1:0]      rx_tick_reg;
  logic [BIT_W-1:0]     rx_bit_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_s0_reg;
  logic                 rx_s1_reg;
  logic                 rx_perr_reg;
  logic                 rx_s;
  logic                 rx_sample;
  logic                 rx_vote;
  logic                 rx_vote_done;
  logic                 rx_bit_end;

  assign rx_s         = rx_sync_reg[1];
  // samples are taken on the first clock of a tick so timing stays exact for any divisor
  assign rx_sample    = (rx_pre_reg == '0);
  assign rx_vote      = (rx_s0_reg & rx_s1_reg) | (rx_s0_reg & rx_s) | (rx_s1_reg & rx_s);
  assign rx_vote_done = rx_sample && (rx_tick_reg == TICK_S2);
  assign rx_bit_end   = (rx_pre_reg == rx_div_reg) && (rx_tick_reg == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_reg   <= 2'b11;
      rx_state_reg  <= S_IDLE;
      rx_div_reg    <= '0;
      rx_pre_reg    <= '0;
      rx_tick_reg   <= '0;
      rx_bit_reg    <= '0;
      rx_shift_reg  <= '0;
      rx_s0_reg     <= 1'b1;
      rx_s1_reg     <= 1'b1;
      rx_perr_reg   <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_sync_reg   <= {rx_sync_reg[0], rx};
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      case (rx_state_reg)
        S_IDLE: begin
          if (!rx_s) begin
            rx_state_reg <= S_START;
            rx_busy      <= 1'b1;
            rx_div_reg   <= baud_div;
            rx_pre_reg   <= '0;
            rx_tick_reg  <= '0;
            rx_bit_reg   <= '0;
            rx_perr_reg  <= 1'b0;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            rx_state_reg <= S_IDLE;
            rx_busy      <= 1'b0;
          end
        end
        default: begin
          if (rx_pre_reg == rx_div_reg) begin
            rx_pre_reg  <= '0;
            rx_tick_reg <= (rx_tick_reg == TICK_LAST) ? '0 : rx_tick_reg + 1'b1;
          end else begin
            rx_pre_reg <= rx_pre_reg + 1'b1;
          end
          if (rx_sample && rx_tick_reg == TICK_S0) rx_s0_reg <= rx_s;
          if (rx_sample && rx_tick_reg == TICK_S1) rx_s1_reg <= rx_s;
          case (rx_state_reg)
            S_START: begin
              if (rx_sample && rx_tick_reg == TICK_S1 && rx_s) begin
                rx_state_reg <= S_IDLE;
                rx_busy      <= 1'b0;
              end else if (rx_bit_end) begin
                rx_state_reg <= S_DATA;
              end
            end
            S_DATA: begin
              if (rx_vote_done) rx_shift_reg <= {rx_vote, rx_shift_reg[DATA_BITS-1:1]};
              if (rx_bit_end) begin
                if (rx_bit_reg == DATA_LAST) begin
                  rx_bit_reg   <= '0;
                  rx_state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                  rx_bit_reg <= rx_bit_reg + 1'b1;
                end
              end
            end
            S_PARITY: begin
              if (rx_vote_done) rx_perr_reg <= (^rx_shift_reg) ^ rx_vote ^ PAR_ODD;
              if (rx_bit_end) rx_state_reg <= S_STOP;
            end
            default: begin
              // report as soon as the first stop bit is voted so back-to-back frames fit
              if (rx_vote_done) begin
                rx_valid      <= 1'b1;
                rx_data       <= rx_shift_reg;
                rx_parity_err <= rx_perr_reg;
                rx_frame_err  <= ~rx_vote;
                if (rx_vote) begin
                  rx_state_reg <= S_IDLE;
                  rx_busy      <= 1'b0;
                end else begin
                  rx_state_reg <= S_BREAK;
                end
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: three instances (8N1, 8E2 loopback, 8O1) driven from one
// process; received frames are checked against a scoreboard of expected results.
module tb_uart_param_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8N1 instance, rx either bench-driven or looped back from tx
  logic [15:0] n1_baud_div;
  logic        n1_tx_start, n1_tx, n1_tx_busy, n1_tx_done;
  logic [7:0]  n1_tx_data, n1_rx_data;
  logic        n1_rx, n1_rx_drv, n1_loop;
  logic        n1_rx_valid, n1_perr, n1_ferr, n1_rx_busy;
  assign n1_rx = n1_loop ? n1_tx : n1_rx_drv;

  // 8E2 instance, permanent loopback
  logic [15:0] e2_baud_div;
  logic        e2_tx_start, e2_tx, e2_tx_busy, e2_tx_done;
  logic [7:0]  e2_tx_data, e2_rx_data;
  logic        e2_rx, e2_rx_valid, e2_perr, e2_ferr, e2_rx_busy;
  assign e2_rx = e2_tx;

  // 8O1 instance, rx bench-driven
  logic [15:0] o1_baud_div;
  logic        o1_tx_start, o1_tx, o1_tx_busy, o1_tx_done;
  logic [7:0]  o1_tx_data, o1_rx_data;
  logic        o1_rx, o1_rx_valid, o1_perr, o1_ferr, o1_rx_busy;

  uart_param_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) u_n1 (
    .clk(clk), .reset(reset), .baud_div(n1_baud_div), .tx_start(n1_tx_start), .tx_data(n1_tx_data),
    .tx(n1_tx), .tx_busy(n1_tx_busy), .tx_done(n1_tx_done), .rx(n1_rx), .rx_data(n1_rx_data),
    .rx_valid(n1_rx_valid), .rx_parity_err(n1_perr), .rx_frame_err(n1_ferr), .rx_busy(n1_rx_busy));

  uart_param_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16), .DIV_W(16)) u_e2 (
    .clk(clk), .reset(reset), .baud_div(e2_baud_div), .tx_start(e2_tx_start), .tx_data(e2_tx_data),
    .tx(e2_tx), .tx_busy(e2_tx_busy), .tx_done(e2_tx_done), .rx(e2_rx), .rx_data(e2_rx_data),
    .rx_valid(e2_rx_valid), .rx_parity_err(e2_perr), .rx_frame_err(e2_ferr), .rx_busy(e2_rx_busy));

  uart_param_core #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) u_o1 (
    .clk(clk), .reset(reset), .baud_div(o1_baud_div), .tx_start(o1_tx_start), .tx_data(o1_tx_data),
    .tx(o1_tx), .tx_busy(o1_tx_busy), .tx_done(o1_tx_done), .rx(o1_rx), .rx_data(o1_rx_data),
    .rx_valid(o1_rx_valid), .rx_parity_err(o1_perr), .rx_frame_err(o1_ferr), .rx_busy(o1_rx_busy));

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop_val;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t q_n1[$];
  exp_t q_e2[$];
  exp_t q_o1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n1_valid_cnt = 0;
  int o1_rise_cyc  = 0;
  int o1_valid_cyc = 0;
  logic o1_busy_prev = 1'b0;
  logic n1_busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_rx(input string tag, input exp_t e, input logic [7:0] d,
                          input logic pe, input logic fe);
    check({tag, " rx_data"}, 32'(d), 32'(e.data));
    check({tag, " rx_parity_err"}, 32'(pe), 32'(e.perr));
    check({tag, " rx_frame_err"}, 32'(fe), 32'(e.ferr));
  endtask

  task automatic unexpected(input string tag, input logic [7:0] d);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected rx_valid with data 0x%02h, expected none", tag, d);
  endtask

  // one clock: sample on the falling edge and retire any received frame
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (o1_rx_busy && !o1_busy_prev) o1_rise_cyc = cyc;
    o1_busy_prev = o1_rx_busy;
    if (n1_rx_busy) n1_busy_seen = 1'b1;
    if (n1_rx_valid) begin
      n1_valid_cnt++;
      $display("rx n1 data=%02h perr=%0b ferr=%0b", n1_rx_data, n1_perr, n1_ferr);
      if (q_n1.size() == 0) unexpected("n1", n1_rx_data);
      else begin
        e = q_n1.pop_front();
        check_rx("n1", e, n1_rx_data, n1_perr, n1_ferr);
      end
    end
    if (e2_rx_valid) begin
      $display("rx e2 data=%02h perr=%0b ferr=%0b", e2_rx_data, e2_perr, e2_ferr);
      if (q_e2.size() == 0) unexpected("e2", e2_rx_data);
      else begin
        e = q_e2.pop_front();
        check_rx("e2", e, e2_rx_data, e2_perr, e2_ferr);
      end
    end
    if (o1_rx_valid) begin
      o1_valid_cyc = cyc;
      $display("rx o1 data=%02h perr=%0b ferr=%0b", o1_rx_data, o1_perr, o1_ferr);
      if (q_o1.size() == 0) unexpected("o1", o1_rx_data);
      else begin
        e = q_o1.pop_front();
        check_rx("o1", e, o1_rx_data, o1_perr, o1_ferr);
      end
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q_n1.size();
      1:       return q_o1.size();
      default: return q_e2.size();
    endcase
  endfunction

  task automatic wait_q(input int sel, input int budget);
    int n = 0;
    while (qsize(sel) != 0 && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (qsize(sel) != 0) begin
      n_fail++;
      $display("FAIL rx_valid missing on dut %0d: %0d frames pending after %0d cycles", sel, qsize(sel), budget);
      case (sel)
        0:       q_n1.delete();
        1:       q_o1.delete();
        default: q_e2.delete();
      endcase
    end
  endtask

  // drive nbits LSB first, each held for t clocks, then return the line to idle
  task automatic send_rx(input int sel, input logic [15:0] bits, input int nbits, input int t);
    for (int b = 0; b < nbits; b++) begin
      if (sel == 0) n1_rx_drv = bits[b];
      else          o1_rx     = bits[b];
      repeat (t) step();
    end
    if (sel == 0) n1_rx_drv = 1'b1;
    else          o1_rx     = 1'b1;
  endtask

  task automatic check_n1_reset(input string tag);
    check({tag, " tx"},            32'(n1_tx), 32'd1);
    check({tag, " tx_busy"},       32'(n1_tx_busy), 32'd0);
    check({tag, " tx_done"},       32'(n1_tx_done), 32'd0);
    check({tag, " rx_valid"},      32'(n1_rx_valid), 32'd0);
    check({tag, " rx_busy"},       32'(n1_rx_busy), 32'd0);
    check({tag, " rx_data"},       32'(n1_rx_data), 32'd0);
    check({tag, " rx_parity_err"}, 32'(n1_perr), 32'd0);
    check({tag, " rx_frame_err"},  32'(n1_ferr), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    logic [9:0]  frame10;
    logic [15:0] bits;
    logic        par;
    int          done_k;
    int          n_done;
    int          c0;
    int          vcnt;

    vecs[0] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hA6, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b0;
    n1_baud_div = '0; n1_tx_start = 1'b0; n1_tx_data = '0; n1_rx_drv = 1'b1; n1_loop = 1'b0;
    e2_baud_div = '0; e2_tx_start = 1'b0; e2_tx_data = '0;
    o1_baud_div = '0; o1_tx_start = 1'b0; o1_tx_data = '0; o1_rx = 1'b1;
    repeat (3) step();
    check_n1_reset("reset");
    check("reset e2 tx", 32'(e2_tx), 32'd1);
    reset = 1'b1;
    repeat (3) step();

    // TX 8N1, T = 64
    n1_baud_div = 16'd3;
    n1_tx_data  = 8'hA5;
    frame10     = {1'b1, 8'hA5, 1'b0};
    n1_tx_start = 1'b1;
    $display("tx n1 start data=A5");
    step();
    n1_tx_start = 1'b0;
    check("n1 tx_busy at accept", 32'(n1_tx_busy), 32'd1);
    check("n1 tx start bit", 32'(n1_tx), 32'd0);
    done_k = -1;
    n_done = 0;
    for (int k = 1; k <= 700; k++) begin
      step();
      if (k % 64 == 32 && k / 64 < 10) check($sformatf("n1 tx bit %0d", k / 64), 32'(n1_tx), 32'(frame10[k / 64]));
      if (n1_tx_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      n1_tx_start = (k == 100);
      n1_tx_data  = (k == 100) ? 8'hFF : 8'hA5;
    end
    check("n1 tx_done latency", 32'(done_k), 32'd640);
    check("n1 tx_done pulse count", 32'(n_done), 32'd1);
    check("n1 busy start ignored", 32'(n1_tx_busy), 32'd0);
    check("n1 tx idle", 32'(n1_tx), 32'd1);

    // 8O1 receive vectors, T = 16
    for (int i = 0; i < 7; i++) begin
      par  = ~(^vecs[i].data) ^ vecs[i].par_flip;
      bits = {5'b11111, vecs[i].stop_val, par, vecs[i].data, 1'b0};
      q_o1.push_back('{vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr});
      c0 = cyc;
      send_rx(1, bits, 11, 16);
      wait_q(1, 100);
      if (i == 0) begin
        check_range("o1 rx_busy latency", o1_rise_cyc - c0, 2, 4);
        check_range("o1 rx_valid latency", o1_valid_cyc - c0, 172, 174);
      end
      repeat (20) step();
      check($sformatf("o1 idle after vec %0d", i), 32'(o1_rx_busy), 32'd0);
    end

    // 8E2 loopback, back-to-back frames
    e2_tx_data  = 8'h3C;
    e2_tx_start = 1'b1;
    q_e2.push_back('{8'h3C, 1'b0, 1'b0});
    $display("tx e2 start data=3C");
    step();
    e2_tx_start = 1'b0;
    done_k = -1;
    for (int k = 1; k <= 300 && done_k < 0; k++) begin
      step();
      if (k == 152) check("e2 parity bit", 32'(e2_tx), 32'd0);
      if (e2_tx_done) done_k = k;
    end
    check("e2 frame length", 32'(done_k), 32'd192);
    e2_tx_data  = 8'hC3;
    e2_tx_start = 1'b1;
    q_e2.push_back('{8'hC3, 1'b0, 1'b0});
    $display("tx e2 start data=C3");
    step();
    e2_tx_start = 1'b0;
    check("e2 back-to-back accept", 32'(e2_tx_busy), 32'd1);
    check("e2 back-to-back start bit", 32'(e2_tx), 32'd0);
    wait_q(2, 400);

    // glitch then a good frame, baud_div = 0
    n1_baud_div  = '0;
    n1_busy_seen = 1'b0;
    vcnt = n1_valid_cnt;
    n1_rx_drv = 1'b0;
    repeat (5) step();
    n1_rx_drv = 1'b1;
    repeat (40) step();
    check("n1 glitch rx_busy pulse", 32'(n1_busy_seen), 32'd1);
    check("n1 glitch back to idle", 32'(n1_rx_busy), 32'd0);
    check("n1 glitch no rx_valid", 32'(n1_valid_cnt - vcnt), 32'd0);
    q_n1.push_back('{8'h55, 1'b0, 1'b0});
    send_rx(0, {6'b111111, 8'h55, 1'b0}, 10, 16);
    wait_q(0, 100);
    repeat (20) step();

    // break: 20 bit periods low
    vcnt = n1_valid_cnt;
    q_n1.push_back('{8'h00, 1'b0, 1'b1});
    n1_rx_drv = 1'b0;
    repeat (320) step();
    check("n1 break rx_busy held", 32'(n1_rx_busy), 32'd1);
    check("n1 break rx_valid count", 32'(n1_valid_cnt - vcnt), 32'd1);
    n1_rx_drv = 1'b1;
    repeat (10) step();
    check("n1 break exit", 32'(n1_rx_busy), 32'd0);
    q_n1.push_back('{8'h81, 1'b0, 1'b0});
    send_rx(0, {6'b111111, 8'h81, 1'b0}, 10, 16);
    wait_q(0, 100);
    repeat (20) step();

    // reset during TX and RX data bits, loopback
    n1_loop     = 1'b1;
    n1_tx_data  = 8'h99;
    n1_tx_start = 1'b1;
    $display("tx n1 start data=99 (to be aborted)");
    step();
    n1_tx_start = 1'b0;
    repeat (64) step();
    check("n1 pre-reset tx_busy", 32'(n1_tx_busy), 32'd1);
    check("n1 pre-reset rx_busy", 32'(n1_rx_busy), 32'd1);
    reset = 1'b0;
    #1;
    check_n1_reset("midframe reset");
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    n1_tx_data  = 8'h7E;
    n1_tx_start = 1'b1;
    q_n1.push_back('{8'h7E, 1'b0, 1'b0});
    $display("tx n1 start data=7E");
    step();
    n1_tx_start = 1'b0;
    done_k = -1;
    for (int k = 1; k <= 300 && done_k < 0; k++) begin
      step();
      if (n1_tx_done) done_k = k;
    end
    check("n1 post-reset frame length", 32'(done_k), 32'd160);
    wait_q(0, 100);
    repeat (20) step();

    check("e2 final rx_busy", 32'(e2_rx_busy), 32'd0);
    check("e2 final tx_busy", 32'(e2_tx_busy), 32'd0);
    check("o1 final tx", 32'(o1_tx), 32'd1);
    check("o1 final tx_busy", 32'(o1_tx_busy), 32'd0);
    check("o1 final tx_done", 32'(o1_tx_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
